// File: rtl/store_merge_unit.sv
// Sub-word store merge: partial stores read the target word, splice in the
// new bytes and write the full word back; full-width stores write directly.
module store_merge_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    localparam int LANES = DATA_W / 8,
    localparam int OFF_W = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [1:0]              req_size,
    input  logic [DATA_W-1:0]       req_data,
    output logic [ADDR_W-OFF_W-1:0] mem_addr,
    output logic                    mem_rd,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    mem_wr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [LANES-1:0]        mem_be,
    output logic                    done,
    output logic                    err
);

    localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        ERR
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-OFF_W-1:0] waddr_q;
    logic [OFF_W-1:0]        off_q;
    logic [1:0]              size_q;
    logic [DATA_W-1:0]       data_q;
    logic [DATA_W-1:0]       merge_q;

    logic [OFF_W-1:0]  amask;
    logic              illegal;
    logic              misaligned;
    logic              full;
    logic [LANES-1:0]  be;
    logic [DATA_W-1:0] bytemask;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] merged;

    // Acceptance-time legality: low size bits of the address must be zero.
    always_comb begin
        amask = '0;
        for (int unsigned k = 0; k < OFF_W; k++) begin
            amask[k] = (k < 32'(req_size));
        end
        illegal    = ({1'b0, req_size} > MAX_SIZE);
        misaligned = |(req_addr[OFF_W-1:0] & amask);
        full       = ({1'b0, req_size} == MAX_SIZE);
    end

    always_comb begin
        be       = '0;
        bytemask = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            be[k] = (k >= 32'(off_q)) && (k < 32'(off_q) + (32'd1 << size_q));
            bytemask[8*k +: 8] = {8{be[k]}};
        end
        shifted = data_q << {off_q, 3'b000};
        merged  = (mem_rdata & ~bytemask) | (shifted & bytemask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (illegal || misaligned) begin
                        state_d = ERR;
                    end else if (full) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                mem_rd   = 1'b1;
                mem_addr = waddr_q;
                state_d  = MERGE;
            end
            MERGE: begin
                state_d = WRITE;
            end
            WRITE: begin
                mem_wr    = 1'b1;
                mem_addr  = waddr_q;
                mem_wdata = merge_q;
                mem_be    = be;
                done      = 1'b1;
                state_d   = IDLE;
            end
            ERR: begin
                err     = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // merge_q is preloaded with the store data so full-width stores need no merge step.
    always_ff @(posedge clk) begin
        if (reset) begin
            waddr_q <= '0;
            off_q   <= '0;
            size_q  <= '0;
            data_q  <= '0;
            merge_q <= '0;
        end else if (state_q == IDLE && req_valid) begin
            waddr_q <= req_addr[ADDR_W-1:OFF_W];
            off_q   <= req_addr[OFF_W-1:0];
            size_q  <= req_size;
            data_q  <= req_data;
            merge_q <= req_data;
        end else if (state_q == MERGE) begin
            merge_q <= merged;
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit at DATA_W = 32: vector table plus
// reset-abort, reset-priority and back-to-back sequences.
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_data;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done;
    logic        err;

    logic [31:0] rd_word;
    int total  = 0;
    int passed = 0;

    store_merge_unit #(.DATA_W(32), .ADDR_W(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_data  (req_data),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // One-cycle read latency; junk is returned when no read is pending.
    always @(posedge clk) begin
        mem_rdata <= mem_rd ? rd_word : 32'hA5A5A5A5;
    end

    typedef struct {
        logic [9:0]  addr;
        logic [1:0]  size;
        logic [31:0] data;
        logic [31:0] word;
        int          exp_rd;
        int          exp_wr;
        int          exp_err;
        logic [7:0]  exp_maddr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int rd_c = 0, wr_c = 0, dn_c = 0, er_c = 0, rdy_c = 0, both = 0;
        logic [31:0] rd_a = '0, wr_a = '0, wd = '0, wbe = '0;
        int exp_rdy;
        @(negedge clk);
        rd_word   = v.word;
        req_addr  = v.addr;
        req_size  = v.size;
        req_data  = v.data;
        req_valid = 1'b1;
        check({tag, " ready_idle"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_rd && rd_c == 0) begin rd_c = c; rd_a = 32'(mem_addr); end
            if (mem_wr && wr_c == 0) begin
                wr_c = c; wr_a = 32'(mem_addr); wd = mem_wdata; wbe = 32'(mem_be);
            end
            if (done && dn_c == 0) dn_c = c;
            if (err && er_c == 0) er_c = c;
            if (req_ready && rdy_c == 0) rdy_c = c;
            if (mem_rd && mem_wr) both = 1;
        end
        exp_rdy = (v.exp_err != 0) ? v.exp_err + 1 : v.exp_wr + 1;
        check({tag, " rd_cycle"}, 32'(rd_c), 32'(v.exp_rd));
        check({tag, " wr_cycle"}, 32'(wr_c), 32'(v.exp_wr));
        check({tag, " done_cycle"}, 32'(dn_c), 32'(v.exp_wr));
        check({tag, " err_cycle"}, 32'(er_c), 32'(v.exp_err));
        check({tag, " ready_cycle"}, 32'(rdy_c), 32'(exp_rdy));
        check({tag, " rd_wr_overlap"}, 32'(both), 32'd0);
        if (rd_c != 0) check({tag, " rd_addr"}, rd_a, 32'(v.exp_maddr));
        if (wr_c != 0) begin
            check({tag, " wr_addr"}, wr_a, 32'(v.exp_maddr));
            check({tag, " wdata"}, wd, v.exp_wdata);
            check({tag, " be"}, wbe, 32'(v.exp_be));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wr_seen;

        vecs[0] = '{10'h001, 2'd0, 32'h000000AB, 32'h11223344, 1, 3, 0, 8'h00, 32'h1122AB44, 4'b0010};
        vecs[1] = '{10'h006, 2'd1, 32'h0000BEEF, 32'hCAFEF00D, 1, 3, 0, 8'h01, 32'hBEEFF00D, 4'b1100};
        vecs[2] = '{10'h008, 2'd2, 32'hDEADBEEF, 32'h00000000, 0, 1, 0, 8'h02, 32'hDEADBEEF, 4'b1111};
        vecs[3] = '{10'h003, 2'd1, 32'h00001234, 32'h00000000, 0, 0, 1, 8'h00, 32'h00000000, 4'b0000};
        vecs[4] = '{10'h000, 2'd3, 32'h00001234, 32'h00000000, 0, 0, 1, 8'h00, 32'h00000000, 4'b0000};
        vecs[5] = '{10'h3FF, 2'd0, 32'hFFFFFF77, 32'h01020304, 1, 3, 0, 8'hFF, 32'h77020304, 4'b1000};
        vecs[6] = '{10'h00C, 2'd1, 32'h12345678, 32'hAABBCCDD, 1, 3, 0, 8'h03, 32'hAABB5678, 4'b0011};
        vecs[7] = '{10'h00E, 2'd0, 32'h0000005A, 32'h00000000, 1, 3, 0, 8'h03, 32'h005A0000, 4'b0100};
        vecs[8] = '{10'h002, 2'd2, 32'h55555555, 32'h00000000, 0, 0, 1, 8'h00, 32'h00000000, 4'b0000};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_size  = '0;
        req_data  = '0;
        rd_word   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst ready", 32'(req_ready), 32'd1);
        check("rst mem_rd", 32'(mem_rd), 32'd0);
        check("rst mem_wr", 32'(mem_wr), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst mem_be", 32'(mem_be), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while the byte store sits in MERGE.
        @(negedge clk);
        rd_word   = 32'h11223344;
        req_addr  = 10'h001;
        req_size  = 2'd0;
        req_data  = 32'h000000AB;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort read", 32'(mem_rd), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort ready", 32'(req_ready), 32'd1);
        wr_seen = mem_wr ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_wr) wr_seen++;
        end
        check("abort no_write", 32'(wr_seen), 32'd0);
        run_vec(vecs[2], "abort sw");

        // Reset wins over a simultaneous full-width request.
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 10'h008;
        req_size  = 2'd2;
        req_data  = 32'hDEADBEEF;
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 1'b0;
        check("rstprio mem_wr", 32'(mem_wr), 32'd0);
        check("rstprio ready", 32'(req_ready), 32'd1);

        // Back-to-back: sw then sb with req_valid held high throughout.
        @(negedge clk);
        req_addr  = 10'h010;
        req_size  = 2'd2;
        req_data  = 32'h0BADF00D;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("b2b sw wr", 32'(mem_wr), 32'd1);
        check("b2b sw done", 32'(done), 32'd1);
        check("b2b sw addr", 32'(mem_addr), 32'h4);
        check("b2b sw wdata", mem_wdata, 32'h0BADF00D);
        check("b2b sw be", 32'(mem_be), 32'hF);
        check("b2b busy", 32'(req_ready), 32'd0);
        rd_word  = 32'h44332211;
        req_addr = 10'h011;
        req_size = 2'd0;
        req_data = 32'h000000C3;
        @(negedge clk);
        check("b2b ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b sb rd", 32'(mem_rd), 32'd1);
        check("b2b sb rd_addr", 32'(mem_addr), 32'h4);
        @(negedge clk);
        @(negedge clk);
        check("b2b sb wr", 32'(mem_wr), 32'd1);
        check("b2b sb done", 32'(done), 32'd1);
        check("b2b sb wdata", mem_wdata, 32'h4433C311);
        check("b2b sb be", 32'(mem_be), 32'h2);
        @(negedge clk);
        check("b2b final ready", 32'(req_ready), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 Parameter DATA_W, default 32, memory word width in bits; legal values 32 and 64.
REQ-002 Parameter ADDR_W, default 10, byte-address width.
REQ-003 Derived constants: LANES = DATA_W/8; OFF_W = log2(LANES); word address = req_addr[ADDR_W-1:OFF_W].
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  store request present.
REQ-007 req_ready  out  1  unit can accept a request this cycle.
REQ-008 req_addr  in  ADDR_W  byte address of store.
REQ-009 req_size  in  2  log2 of store bytes: 0 byte, 1 half, 2 word, 3 dword.
REQ-010 req_data  in  DATA_W  store data, right-justified in the low bytes.
REQ-011 mem_addr  out  ADDR_W-OFF_W  word address to data memory.
REQ-012 mem_rd  out  1  read strobe; memory returns mem_rdata on the next cycle.
REQ-013 mem_rdata  in  DATA_W  read data from memory.
REQ-014 mem_wr  out  1  write strobe.
REQ-015 mem_wdata  out  DATA_W  merged full-word write data.
REQ-016 mem_be  out  LANES  byte enables of the lanes written by the store (informational).
REQ-017 done  out  1  one-cycle pulse: store committed.
REQ-018 err  out  1  one-cycle pulse: request rejected.

Function
REQ-019 FSM states IDLE, READ, MERGE, WRITE, ERR; req_ready = 1 only in IDLE.
REQ-020 A request is accepted on an edge where req_valid && req_ready; addr, size and data are registered at acceptance.
REQ-021 Size-legality check at acceptance: size > log2(LANES) -> illegal; addr[size-1:0] != 0 -> misaligned; both go to ERR.
REQ-022 Full-width store (2^size == LANES): IDLE -> WRITE, with no memory read.
REQ-023 Partial store: IDLE -> READ -> MERGE -> WRITE.
REQ-024 READ: mem_rd = 1; mem_addr = registered word address.
REQ-025 MERGE: the merge register captures mem_rdata with lanes [off, off+2^size-1] replaced by req_data bytes [0, 2^size-1].
REQ-026 off = addr[OFF_W-1:0]; lane k occupies bits [8k+7:8k] (little-endian).
REQ-027 WRITE: mem_wr = 1; mem_addr = word address; mem_wdata = merge register (or registered req_data for full-width); mem_be = enabled lanes; done = 1; next state IDLE.
REQ-028 ERR: err = 1 for one cycle; mem_rd = mem_wr = 0; next state IDLE.
REQ-029 Latency from the acceptance edge: full-width done in the 1st following cycle, partial in the 3rd, error in the 1st.
REQ-030 Throughput: req_ready rises the cycle after WRITE or ERR; back-to-back requests are accepted without idle gaps beyond that.
REQ-031 mem_rd and mem_wr are never asserted in the same cycle; outside READ and WRITE both are 0.
REQ-032 req_valid in non-IDLE states is ignored; no queuing.
REQ-033 mem_rdata is sampled only in MERGE; its value in other cycles has no effect.

Reset
REQ-034 When reset is high at an edge, state -> IDLE and the registered request is discarded.
REQ-035 Output values after reset: req_ready = 1; mem_rd, mem_wr, done, err = 0; mem_addr, mem_wdata, mem_be = 0.
REQ-036 Reset in any state, including MERGE or WRITE, aborts the operation; no mem_wr is issued after the reset edge.
REQ-037 Reset takes priority over a simultaneous req_valid.

Verification (DATA_W = 32)
REQ-038 Byte store: sb, addr 0x001, data 0x000000AB, memory word 0 = 0x11223344 -> mem_rd at T+1; mem_wr at T+3 with addr 0, wdata 0x1122AB44, be 0010; done = 1.
REQ-039 Half store: sh, addr 0x006, data 0x0000BEEF, word 1 = 0xCAFEF00D -> at T+3 wdata 0xBEEFF00D, be 1100.
REQ-040 Word store: sw, addr 0x008, data 0xDEADBEEF -> no mem_rd; mem_wr at T+1 with addr 2, wdata 0xDEADBEEF, be 1111.
REQ-041 Errors: sh at addr 0x003, or size 3 -> err pulse at T+1, no mem_rd or mem_wr, req_ready = 1 at T+2.
REQ-042 Reset while in MERGE of a byte store -> no mem_wr ever; req_ready = 1 the cycle after reset; next sw completes normally.
REQ-043 Back-to-back: sw then sb held on req_valid -> second request accepted the cycle after the first done; both writes are correct.
